codec_avalon_loopback_master: RTL
=================================

// Module: codec_avalon_loopback_master
// PURPOSE
//  Avalon-MM burst master that drives the codec slave register port from the other end.
//  After start, it polls STATUS_AUDIO and burst-reads BURST_LEN samples from ADC_AUDIO
//  into an internal buffer. It then polls again and burst-writes the same samples to DAC_AUDIO.
//  Provides a hardware audio loopback/DMA path and sits beside the CPU on the codec slave port.
// PARAMETERS
//  BURST_LEN   4     beats per read/write burst; legal 1..16
//  ADDR_STATUS 3'd1  STATUS_AUDIO register address
//  ADDR_DAC    3'd2  DAC_AUDIO register address
//  ADDR_ADC    3'd3  ADC_AUDIO register address
// PORTS
//  Clk                        in   1   clock
//  Rst_n                      in   1   reset; asynchronous, active-high
//  start                      in   1   1-cycle pulse: begin continuous loopback
//  stop                       in   1   1-cycle pulse: halt after current burst pair completes
//  master_chipselect          out  1   asserted with every read/write beat
//  master_read                out  1   read request
//  master_write               out  1   write request
//  master_address             out  3   register address
//  master_writedata           out  32  write data
//  master_readdata            in   32  read data, valid in the same cycle as read & !waitrequest
//  master_waitrequest         in   1   slave stall; beat accepted only when low
//  master_beginbursttransfer  out  1   1-cycle burst start marker
//  master_burstcount          out  8   BURST_LEN, valid with beginbursttransfer
//  busy                       out  1   high when not in IDLE
//  frames_done                out  16  completed read+write burst pairs; wraps 16'hFFFF->0
//  adc_overrun                out  1   sticky; set when status bit2 (adc_fifo_full) is seen; cleared by start
// BEHAVIOUR
//  Reset (async, Rst_n=1):
//   - All outputs are 0, the FSM is in IDLE, and buffer/counters are cleared.
//   - Reset asserted mid-burst drops read/write in the same cycle; no completion is required.
//  STATUS_AUDIO bits: [0] i2c_idle, [1] dac_fifo_full, [2] adc_fifo_full, [3] adc_fifo_empty.
//  Beat accept: a beat completes on a cycle with (read|write) & chipselect & !waitrequest.
//   - Read data is captured on that same edge.
//   - Address, data and request are held stable while waitrequest=1.
//  FSM states:
//   IDLE:
//    - start -> POLL_ADC; adc_overrun is cleared.
//   POLL_ADC: single read of ADDR_STATUS, burstcount=1, no beginbursttransfer.
//    - On accept: if bit3=1 -> POLL_ADC again (re-poll next cycle); else -> RD_BURST.
//    - Bit2 sampled here sets adc_overrun.
//   RD_BURST: read=1, address=ADDR_ADC, burstcount=BURST_LEN.
//    - beginbursttransfer=1 only in the first cycle of the state, even if stalled.
//    - Each accepted beat stores readdata into buf[beat_cnt], beat_cnt++.
//    - After beat BURST_LEN-1 is accepted -> POLL_DAC; read drops the next cycle.
//   POLL_DAC: single read of ADDR_STATUS.
//    - bit1=1 -> re-poll; else -> WR_BURST.
//   WR_BURST: write=1, address=ADDR_DAC, writedata=buf[beat_cnt].
//    - beginbursttransfer on the first cycle only, as in RD_BURST.
//    - Each accepted beat increments beat_cnt.
//    - After the last beat: frames_done++; stop_pending ? IDLE : POLL_ADC.
//  stop:
//   - Latched into stop_pending in any state; in IDLE it is ignored.
//   - A stop in POLL_ADC goes to IDLE at the next accept without issuing a burst.
//   - A burst in progress is never truncated.
//  start while busy: ignored. start and stop in the same cycle from IDLE: stop wins, stay IDLE.
//  At most one of read/write is high in any cycle. chipselect = read|write.
//  beat_cnt is clog2(BURST_LEN)+1 bits wide and resets to 0 on every burst entry.
//  Latency: POLL beats take 1 cycle each at zero wait.
//   - Minimum pair is 2+2*BURST_LEN cycles.
//   - With no wait states there is no idle cycle between consecutive states.
//  busy = (state != IDLE).
// TESTING
//  1. No waitrequest, status=0, BURST_LEN=4, ADC returns 0xA1..0xA4, start
//     -> 4 DAC writes 0xA1..0xA4 in order; frames_done=1 after 10 cycles.
//  2. waitrequest=1 for 3 cycles on read beat 2
//     -> address/read held; buffer contents unchanged; total pair takes 13 cycles.
//  3. status bit3=1 for 5 polls, then 0
//     -> 5 extra ADDR_STATUS reads; no ADDR_ADC access until the 6th poll.
//  4. status bit1=1 during POLL_DAC
//     -> no DAC write until it clears; buffer is preserved. Bit2=1 in POLL_ADC -> adc_overrun=1
//        until the next start.
//  5. stop during RD_BURST
//     -> the read burst and write burst both complete; frames_done+1; IDLE; busy=0.
//  6. Rst_n pulse mid WR_BURST
//     -> read/write/chipselect=0 immediately; frames_done=0; a fresh start behaves as in test 1.

Source files
------------

// File: rtl/codec_avalon_loopback_master_if.sv
// Avalon-MM register-port bundle shared by the loopback master and the codec slave.
interface codec_avalon_loopback_master_if;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        beginbursttransfer;
  logic [7:0]  burstcount;

  modport master (
    output chipselect, read, write, address, writedata, beginbursttransfer, burstcount,
    input  readdata, waitrequest
  );

  modport slave (
    input  chipselect, read, write, address, writedata, beginbursttransfer, burstcount,
    output readdata, waitrequest
  );
endinterface

// File: rtl/codec_avalon_loopback_master.sv
// Avalon-MM burst master looping codec ADC samples back to the DAC:
// poll status, burst-read ADC into a buffer, poll status, burst-write the buffer to the DAC.
module codec_avalon_loopback_master #(
  parameter int unsigned BURST_LEN   = 4,
  parameter logic [2:0]  ADDR_STATUS = 3'd1,
  parameter logic [2:0]  ADDR_DAC    = 3'd2,
  parameter logic [2:0]  ADDR_ADC    = 3'd3
) (
  input  logic                                  Clk,
  input  logic                                  Rst_n,
  input  logic                                  start,
  input  logic                                  stop,
  codec_avalon_loopback_master_if.master        avm,
  output logic                                  busy,
  output logic [15:0]                           frames_done,
  output logic                                  adc_overrun
);
  localparam int unsigned      CNT_W     = $clog2(BURST_LEN) + 1;
  localparam int unsigned      IDX_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_POLL_ADC = 3'd1;
  localparam logic [2:0] S_RD_BURST = 3'd2;
  localparam logic [2:0] S_POLL_DAC = 3'd3;
  localparam logic [2:0] S_WR_BURST = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             first_q, first_d;
  logic             stop_pending_q, stop_pending_d;
  logic [15:0]      frames_q, frames_d;
  logic             overrun_q, overrun_d;
  logic [31:0]      sample_buf_q [BURST_LEN];
  logic [31:0]      sample_buf_d [BURST_LEN];

  logic             accept;
  logic             stop_now;
  logic             last_beat;
  logic [IDX_W-1:0] beat_idx;

  assign beat_idx  = beat_cnt_q[IDX_W-1:0];
  assign last_beat = (beat_cnt_q == LAST_BEAT);
  // A stop arriving on the very cycle of the deciding beat still counts.
  assign stop_now  = stop_pending_q | stop;

  // Bus outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    avm.read               = 1'b0;
    avm.write              = 1'b0;
    avm.address            = '0;
    avm.writedata          = '0;
    avm.burstcount         = '0;
    avm.beginbursttransfer = 1'b0;
    case (state_q)
      S_POLL_ADC, S_POLL_DAC: begin
        avm.read       = 1'b1;
        avm.address    = ADDR_STATUS;
        avm.burstcount = 8'd1;
      end
      S_RD_BURST: begin
        avm.read               = 1'b1;
        avm.address            = ADDR_ADC;
        avm.burstcount         = 8'(BURST_LEN);
        avm.beginbursttransfer = first_q;
      end
      S_WR_BURST: begin
        avm.write              = 1'b1;
        avm.address            = ADDR_DAC;
        avm.writedata          = sample_buf_q[beat_idx];
        avm.burstcount         = 8'(BURST_LEN);
        avm.beginbursttransfer = first_q;
      end
      default: ;
    endcase
  end

  assign avm.chipselect = avm.read | avm.write;
  assign accept         = (avm.read | avm.write) & avm.chipselect & ~avm.waitrequest;

  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    first_d        = 1'b0;
    stop_pending_d = stop_pending_q;
    frames_d       = frames_q;
    overrun_d      = overrun_q;
    sample_buf_d   = sample_buf_q;

    if (state_q != S_IDLE && stop) stop_pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d        = S_POLL_ADC;
          overrun_d      = 1'b0;
          stop_pending_d = 1'b0;
        end
      end
      S_POLL_ADC: begin
        if (accept) begin
          if (avm.readdata[2]) overrun_d = 1'b1;
          if (stop_now) begin
            state_d        = S_IDLE;
            stop_pending_d = 1'b0;
          end else if (!avm.readdata[3]) begin
            state_d    = S_RD_BURST;
            beat_cnt_d = '0;
            first_d    = 1'b1;
          end
        end
      end
      S_RD_BURST: begin
        if (accept) begin
          sample_buf_d[beat_idx] = avm.readdata;
          beat_cnt_d             = beat_cnt_q + 1'b1;
          if (last_beat) state_d = S_POLL_DAC;
        end
      end
      S_POLL_DAC: begin
        if (accept && !avm.readdata[1]) begin
          state_d    = S_WR_BURST;
          beat_cnt_d = '0;
          first_d    = 1'b1;
        end
      end
      S_WR_BURST: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            frames_d = frames_q + 16'd1;
            if (stop_now) begin
              state_d        = S_IDLE;
              stop_pending_d = 1'b0;
            end else begin
              state_d = S_POLL_ADC;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst_n) begin
    if (Rst_n) begin
      state_q        <= S_IDLE;
      beat_cnt_q     <= '0;
      first_q        <= 1'b0;
      stop_pending_q <= 1'b0;
      frames_q       <= '0;
      overrun_q      <= 1'b0;
      for (int i = 0; i < int'(BURST_LEN); i++) sample_buf_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      first_q        <= first_d;
      stop_pending_q <= stop_pending_d;
      frames_q       <= frames_d;
      overrun_q      <= overrun_d;
      sample_buf_q   <= sample_buf_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign frames_done = frames_q;
  assign adc_overrun = overrun_q;
endmodule
